// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: FSM state type, default
// address/data widths and a helper sizing the burst counter.
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    localparam int DMEM_ADR_W  = 5;
    localparam int DMEM_DATA_W = 32;

    // Counter width for a burst limit of n; never narrower than one bit so a
    // limit of 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter in front of a single-port data memory.  Port 0 is the CPU,
// port 1 the loader/DMA.  Grants are registered (state GRANT0/GRANT1); while a
// port holds the grant and keeps requesting, one access happens per cycle and
// an ack pulse with (for reads) the captured data follows one cycle later.
//
// Default build: round-robin.  A granted port may make MAX_BURST consecutive
// accesses while the other port waits, then the grant moves over.
// DMEM_ARB_CPU_PRIO_EN: fixed priority.  Port 0 wins ties and keeps the grant
// for as long as it requests; port 1 yields after any access once Req0 is up.
//
// Ports
//   i_Clk, i_Reset                 clock, synchronous active-low reset
//   i_Req0/1, i_We0/1              request, write(1)/read(0)
//   i_Adr0/1 [ADR_W], i_WData0/1   word address, write data
//   o_Gnt0/1                       registered grant
//   o_Ack0/1                       registered one-cycle completion pulse
//   o_RData [DATA_W]               registered read data (qualified by ack)
//   o_Stall0                       Req0 & ~Gnt0, freezes the CPU PC
//   o_DMemR/o_DMemW                memory read/write enables
//   o_DataAdr, o_DataIn            memory address / write data
//   i_DataOut                      memory read data (combinational)
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int ADR_W     = DMEM_ADR_W,
    parameter int DATA_W    = DMEM_DATA_W
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Req0,
    input  logic              i_Req1,
    input  logic              i_We0,
    input  logic              i_We1,
    input  logic [ADR_W-1:0]  i_Adr0,
    input  logic [ADR_W-1:0]  i_Adr1,
    input  logic [DATA_W-1:0] i_WData0,
    input  logic [DATA_W-1:0] i_WData1,
    output logic              o_Gnt0,
    output logic              o_Gnt1,
    output logic              o_Ack0,
    output logic              o_Ack1,
    output logic [DATA_W-1:0] o_RData,
    output logic              o_Stall0,
    output logic              o_DMemR,
    output logic              o_DMemW,
    output logic [ADR_W-1:0]  o_DataAdr,
    output logic [DATA_W-1:0] o_DataIn,
    input  logic [DATA_W-1:0] i_DataOut
);

    localparam int               CNT_W    = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;      // 1: port 1 was served last
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata;

    arb_state_e        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_last_nxt;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_burst_end;

    // An access happens only while the granted port is still requesting.
    assign w_acc0      = (r_state == GRANT0) && i_Req0;
    assign w_acc1      = (r_state == GRANT1) && i_Req1;
    assign w_burst_end = (r_cnt == CNT_LAST);

    assign o_Gnt0   = (r_state == GRANT0);
    assign o_Gnt1   = (r_state == GRANT1);
    assign o_Ack0   = r_ack0;
    assign o_Ack1   = r_ack1;
    assign o_RData  = r_rdata;
    assign o_Stall0 = i_Req0 & ~o_Gnt0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (i_Req0 && i_Req1) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                    w_state_nxt = GRANT0;
`else
                    w_state_nxt = r_last ? GRANT0 : GRANT1;
`endif
                end else if (i_Req0) begin
                    w_state_nxt = GRANT0;
                end else if (i_Req1) begin
                    w_state_nxt = GRANT1;
                end
            end

            GRANT0: begin
                if (!i_Req0) begin
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = i_Req1 ? GRANT1 : IDLE;
                end else begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                    // CPU is never limited; counter just wraps.
                    w_cnt_nxt = w_burst_end ? '0 : r_cnt + 1'b1;
`else
                    if (w_burst_end) begin
                        // Limit reached: hand over if port 1 waits, otherwise
                        // start a fresh burst window without saturating.
                        w_cnt_nxt = '0;
                        if (i_Req1) begin
                            w_state_nxt = GRANT1;
                            w_last_nxt  = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
`endif
                end
            end

            GRANT1: begin
                if (!i_Req1) begin
                    w_last_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = i_Req0 ? GRANT0 : IDLE;
                end else begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                    // Loader gives way after its current access once the CPU asks.
                    if (i_Req0) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = GRANT0;
                        w_last_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = w_burst_end ? '0 : r_cnt + 1'b1;
                    end
`else
                    if (w_burst_end) begin
                        w_cnt_nxt = '0;
                        if (i_Req0) begin
                            w_state_nxt = GRANT0;
                            w_last_nxt  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
`endif
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;        // port 0 wins the first tie
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Memory side: driven straight from the accessing port, else all zero.
    // ------------------------------------------------------------------
    always_comb begin
        o_DMemR   = 1'b0;
        o_DMemW   = 1'b0;
        o_DataAdr = '0;
        o_DataIn  = '0;
        if (w_acc0) begin
            o_DMemR   = ~i_We0;
            o_DMemW   = i_We0;
            o_DataAdr = i_Adr0;
            o_DataIn  = i_WData0;
        end else if (w_acc1) begin
            o_DMemR   = ~i_We1;
            o_DMemW   = i_We1;
            o_DataAdr = i_Adr1;
            o_DataIn  = i_WData1;
        end
    end

    // Completion: ack one cycle after the access; reads capture memory data,
    // writes leave the last read value in place.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack0 <= w_acc0;
            r_ack1 <= w_acc1;
            if ((w_acc0 && !i_We0) || (w_acc1 && !i_We1))
                r_rdata <= i_DataOut;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus a long randomized run checked every cycle against a
// behavioural ownership model.
module tb_dmem_arbiter;

    localparam int MAXB = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
`ifdef DMEM_ARB_CPU_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] adr0 = '0, adr1 = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic          gnt0, gnt1, ack0, ack1, stall0, dmemr, dmemw;
    logic [AW-1:0] dadr;
    logic [DW-1:0] din, rdata, dout;
    logic [DW-1:0] mem [2**AW];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(MAXB), .ADR_W(AW), .DATA_W(DW)) dut (
        .i_Clk(clk), .i_Reset(rst_n),
        .i_Req0(req0), .i_Req1(req1), .i_We0(we0), .i_We1(we1),
        .i_Adr0(adr0), .i_Adr1(adr1), .i_WData0(wd0), .i_WData1(wd1),
        .o_Gnt0(gnt0), .o_Gnt1(gnt1), .o_Ack0(ack0), .o_Ack1(ack1),
        .o_RData(rdata), .o_Stall0(stall0), .o_DMemR(dmemr), .o_DMemW(dmemw),
        .o_DataAdr(dadr), .o_DataIn(din), .i_DataOut(dout)
    );

    // Memory environment: combinational read, refilled with known contents on reset.
    function automatic logic [DW-1:0] seed(int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hA5000000 | (DW'(i) * 32'h00010203));
    endfunction

    assign dout = mem[dadr];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= seed(i);
        end else if (dmemw) begin
            mem[dadr] <= din;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who owns the memory, how many accesses it has made
    // in its current run, and who was served last.
    // ------------------------------------------------------------------
    int            m_own = -1;     // -1 nobody, else port number
    int            m_run = 0;
    int            m_last = 1;
    bit            m_ack [2];
    logic [DW-1:0] m_rdata = '0;
    bit            m_valid = 1'b0;

    always @(negedge clk) begin : compare
        bit            rq [2];
        bit            w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        bit            acc;
        bit            yield;
        int            k, o;
        rq[0] = req0; rq[1] = req1;
        w[0]  = we0;  w[1]  = we1;
        a[0]  = adr0; a[1]  = adr1;
        d[0]  = wd0;  d[1]  = wd1;
        k   = (m_own < 0) ? 0 : m_own;
        o   = 1 - k;
        acc = (m_own >= 0) && rq[k];
        if (m_valid) begin
            chk("gnt", {30'd0, gnt0, gnt1}, {30'd0, m_own == 0, m_own == 1});
            chk("ack", {30'd0, ack0, ack1}, {30'd0, m_ack[0], m_ack[1]});
            chk("rdata", rdata, m_rdata);
            chk("stall0", {31'd0, stall0}, {31'd0, rq[0] && m_own != 0});
            chk("mem_en", {30'd0, dmemr, dmemw}, acc ? {30'd0, !w[k], w[k]} : 32'd0);
            chk("data_adr", {27'd0, dadr}, acc ? {27'd0, a[k]} : 32'd0);
            chk("data_in", din, acc ? d[k] : 32'd0);
            chk("exclusive", {30'd0, gnt0 & gnt1, ack0 & ack1}, 32'd0);
        end
        if (!rst_n) begin
            m_own = -1; m_run = 0; m_last = 1;
            m_ack[0] = 0; m_ack[1] = 0;
            m_rdata = '0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_ack[0] = acc && (k == 0);
            m_ack[1] = acc && (k == 1);
            if (acc && !w[k]) m_rdata = mem[a[k]];
            if (m_own < 0) begin
                if (rq[0] && rq[1]) m_own = PRIO ? 0 : ((m_last == 1) ? 0 : 1);
                else if (rq[0])     m_own = 0;
                else if (rq[1])     m_own = 1;
                m_run = 0;
            end else if (!rq[k]) begin
                m_last = k;
                m_own  = rq[o] ? o : -1;
                m_run  = 0;
            end else begin
                m_run = m_run + 1;
                yield = PRIO ? (k == 1 && rq[0]) : (m_run == MAXB && rq[o]);
                if (yield) begin
                    m_last = k; m_own = o; m_run = 0;
                end else begin
                    m_run = m_run % MAXB;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        bit hold0, hold1, seen;

        // Reset held with both ports requesting: registered outputs stay 0.
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        step();
        at_neg();
        chk("rst_ctl", {26'd0, gnt0, gnt1, ack0, ack1, dmemr, dmemw}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        step();
        rst_n = 1'b1;
        at_neg();
        chk("rst_ctl2", {26'd0, gnt0, gnt1, ack0, ack1, dmemr, dmemw}, 32'd0);
        step();
        at_neg();
        chk("first_tie_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
        step();
        req0 = 1'b0; req1 = 1'b0;
        step(); step(); step();

        // Single read from the CPU port.
        req0 = 1'b1; we0 = 1'b0; adr0 = 5'd5;
        at_neg();
        chk("rd_c0_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rd_c0_stall", {31'd0, stall0}, 32'd1);
        step();
        at_neg();
        chk("rd_c1_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rd_c1_en", {30'd0, dmemr, dmemw}, 32'd2);
        chk("rd_c1_adr", {27'd0, dadr}, 32'd5);
        step();
        req0 = 1'b0;
        at_neg();
        chk("rd_c2_ack0", {31'd0, ack0}, 32'd1);
        chk("rd_c2_rdata", rdata, 32'hDEADBEEF);
        step(); step();

        // Single write from the loader port.
        req1 = 1'b1; we1 = 1'b1; adr1 = 5'd31; wd1 = 32'h12345678;
        at_neg();
        chk("wr_c0_gnt1", {31'd0, gnt1}, 32'd0);
        step();
        at_neg();
        chk("wr_c1_gnt1", {31'd0, gnt1}, 32'd1);
        chk("wr_c1_en", {30'd0, dmemr, dmemw}, 32'd1);
        chk("wr_c1_din", din, 32'h12345678);
        chk("wr_c1_adr", {27'd0, dadr}, 32'd31);
        step();
        req1 = 1'b0; we1 = 1'b0;
        at_neg();
        chk("wr_c2_ack", {30'd0, ack0, ack1}, 32'd1);
        chk("wr_c2_rdata", rdata, 32'hDEADBEEF);
        step(); step();

        // Both ports requesting continuously.
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; adr0 = 5'd3; adr1 = 5'd7;
        for (int i = 1; i <= 12; i++) begin
            bit eg0;
            step();
            at_neg();
            eg0 = PRIO ? 1'b1 : ((((i - 1) / MAXB) % 2) == 0);
            chk("alt_gnt", {30'd0, gnt0, gnt1}, {30'd0, eg0, !eg0});
            chk("alt_ack_excl", {31'd0, ack0 & ack1}, 32'd0);
        end
        step();
        req0 = 1'b0; req1 = 1'b0;
        step(); step(); step();

        // Reset in the second cycle of a loader write burst.
        req1 = 1'b1; we1 = 1'b1; adr1 = 5'd9; wd1 = 32'hCAFEF00D;
        step();
        step();
        at_neg();
        chk("rb_c2_gnt1", {31'd0, gnt1}, 32'd1);
        rst_n = 1'b0;
        // rst_n changed after the negedge sample, before the closing edge
        step();
        rst_n = 1'b1;
        at_neg();
        chk("rb_c3_ctl", {29'd0, gnt1, dmemw, ack1}, 32'd0);
        step();
        req1 = 1'b0; we1 = 1'b0;
        at_neg();
        chk("rb_c4_ack1", {31'd0, ack1}, 32'd0);
        step();
        at_neg();
        chk("rb_c5_ack1", {31'd0, ack1}, 32'd0);
        step(); step();

`ifdef DMEM_ARB_CPU_PRIO_EN
        // Loader bursting, CPU arrives and must take over and keep the grant.
        req1 = 1'b1; we1 = 1'b0; adr1 = 5'd2;
        step(); step(); step();
        req0 = 1'b1; we0 = 1'b0; adr0 = 5'd4;
        seen = 1'b0;
        for (int j = 0; j < 2 && !seen; j++) begin
            step();
            at_neg();
            seen = gnt0;
        end
        chk("prio_gnt0_within2", {31'd0, seen}, 32'd1);
        for (int j = 0; j < MAXB + 2; j++) begin
            step();
            at_neg();
            chk("prio_gnt0_hold", {31'd0, gnt0}, 32'd1);
        end
        step();
        req0 = 1'b0; req1 = 1'b0;
        step(); step();
`else
        seen = 1'b0;
`endif

        // Randomized traffic; a requester holds its request until granted.
        for (int n = 0; n < 4000; n++) begin
            hold0 = req0 && !gnt0;
            hold1 = req1 && !gnt1;
            step();
            rst_n = ($urandom_range(0, 249) != 0);
            if (!hold0) begin
                req0 = ($urandom_range(0, 9) < 6);
                we0  = $urandom_range(0, 1);
                adr0 = AW'($urandom);
                wd0  = $urandom;
            end
            if (!hold1) begin
                req1 = ($urandom_range(0, 9) < 7);
                we1  = $urandom_range(0, 1);
                adr1 = AW'($urandom);
                wd1  = $urandom;
            end
        end
        step();
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step(); step();
        at_neg();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
